// File: rtl/dcmac_reset_sequencer_if.sv
// GT-side signal bundle between the reset sequencer (master) and the DCMAC/GT helper (slave).
interface dcmac_reset_sequencer_if;
  // All signals are levels, not valid/ready transfers: a reset output is active
  // while high, and a done input stays high for as long as that direction is up.
  logic [1:0] gt_rx_reset_done;
  logic [1:0] gt_tx_reset_done;
  logic       user_gt_reset_all;
  logic [1:0] user_gt_reset_rx_datapath;
  logic [1:0] link_ready;

  modport master (
    input  gt_rx_reset_done,
    input  gt_tx_reset_done,
    output user_gt_reset_all,
    output user_gt_reset_rx_datapath,
    output link_ready
  );

  modport slave (
    output gt_rx_reset_done,
    output gt_tx_reset_done,
    input  user_gt_reset_all,
    input  user_gt_reset_rx_datapath,
    input  link_ready
  );
endinterface

// File: rtl/dcmac_reset_sequencer.sv
// DCMAC GT reset sequencer: waits for clock lock, pulses a full GT reset, waits for the
// per-port reset-done flags with timeout/retry, and re-resets RX datapaths that drop.
module dcmac_reset_sequencer #(
  parameter int unsigned RESET_CYCLES   = 100,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic                           s_axi_clk,
  input  logic                           s_axi_aresetn,
  input  logic                           clkwiz_locked,
  input  logic                           restart,
  dcmac_reset_sequencer_if.master        gt,
  output logic                           busy,
  output logic                           error,
  output logic [3:0]                     retry_count,
  output logic [2:0]                     state
);

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    ASSERT_ALL = 3'd1,
    WAIT_DONE  = 3'd2,
    READY      = 3'd3,
    RX_RESET   = 3'd4,
    FAIL       = 3'd5
  } state_t;

  // Counters hold "cycles remaining minus one" so the state lasts exactly N clocks.
  localparam logic [15:0] PULSE_LAST   = 16'(RESET_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRIES);

  logic        lock_meta;
  logic        locked_s;
  state_t      st;
  logic [15:0] pulse_cnt;
  logic [31:0] timer;
  logic [1:0]  mask;
  logic        all_done;

  assign all_done = (&gt.gt_rx_reset_done) && (&gt.gt_tx_reset_done);
  assign state    = st;

  always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= clkwiz_locked;
      locked_s  <= lock_meta;
    end
  end

  always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      st                           <= WAIT_LOCK;
      pulse_cnt                    <= '0;
      timer                        <= '0;
      mask                         <= '0;
      retry_count                  <= '0;
      gt.user_gt_reset_all         <= 1'b1;
      gt.user_gt_reset_rx_datapath <= '0;
      gt.link_ready                <= '0;
      busy                         <= 1'b1;
      error                        <= 1'b0;
    end else if (!locked_s) begin
      // Lock loss overrides everything, including a simultaneous restart.
      st                           <= WAIT_LOCK;
      mask                         <= '0;
      gt.user_gt_reset_all         <= 1'b1;
      gt.user_gt_reset_rx_datapath <= '0;
      gt.link_ready                <= '0;
      busy                         <= 1'b1;
      error                        <= 1'b0;
    end else if (restart && (st != WAIT_LOCK)) begin
      st                           <= ASSERT_ALL;
      pulse_cnt                    <= PULSE_LAST;
      retry_count                  <= '0;
      mask                         <= '0;
      gt.user_gt_reset_all         <= 1'b1;
      gt.user_gt_reset_rx_datapath <= '0;
      gt.link_ready                <= '0;
      busy                         <= 1'b1;
      error                        <= 1'b0;
    end else begin
      case (st)
        WAIT_LOCK: begin
          st        <= ASSERT_ALL;
          pulse_cnt <= PULSE_LAST;
        end
        ASSERT_ALL: begin
          if (pulse_cnt == '0) begin
            st                   <= WAIT_DONE;
            timer                <= '0;
            gt.user_gt_reset_all <= 1'b0;
          end else begin
            pulse_cnt <= pulse_cnt - 16'd1;
          end
        end
        WAIT_DONE: begin
          // Done is checked first so it wins over a same-cycle timeout.
          if (all_done) begin
            st            <= READY;
            retry_count   <= '0;
            gt.link_ready <= gt.gt_rx_reset_done & gt.gt_tx_reset_done;
            busy          <= 1'b0;
          end else if (timer >= TIMEOUT_LAST) begin
            if (retry_count < RETRY_MAX) begin
              st                   <= ASSERT_ALL;
              pulse_cnt            <= PULSE_LAST;
              retry_count          <= retry_count + 4'd1;
              gt.user_gt_reset_all <= 1'b1;
            end else begin
              st    <= FAIL;
              busy  <= 1'b0;
              error <= 1'b1;
            end
          end else if (timer != '1) begin
            timer <= timer + 32'd1;
          end
        end
        READY: begin
          if (!(&gt.gt_rx_reset_done)) begin
            st                           <= RX_RESET;
            pulse_cnt                    <= PULSE_LAST;
            mask                         <= ~gt.gt_rx_reset_done;
            gt.user_gt_reset_rx_datapath <= ~gt.gt_rx_reset_done;
            gt.link_ready                <= '0;
            busy                         <= 1'b1;
          end else begin
            gt.link_ready <= gt.gt_rx_reset_done & gt.gt_tx_reset_done;
          end
        end
        RX_RESET: begin
          if (pulse_cnt == '0) begin
            st                           <= WAIT_DONE;
            timer                        <= '0;
            mask                         <= '0;
            gt.user_gt_reset_rx_datapath <= '0;
          end else begin
            pulse_cnt                    <= pulse_cnt - 16'd1;
            gt.user_gt_reset_rx_datapath <= mask;
          end
        end
        FAIL: begin
          st <= FAIL;
        end
        default: begin
          st                           <= WAIT_LOCK;
          mask                         <= '0;
          gt.user_gt_reset_all         <= 1'b1;
          gt.user_gt_reset_rx_datapath <= '0;
          gt.link_ready                <= '0;
          busy                         <= 1'b1;
          error                        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcmac_reset_sequencer.sv
// Bench for dcmac_reset_sequencer: per-cycle expected output vectors built from phase
// durations (lock latency, pulse width, timeout, retries) and compared at each negedge.
module tb_dcmac_reset_sequencer;
  localparam int RST_CYC = 100;
  localparam int TO_CYC  = 1000;
  localparam int MAX_RT  = 3;

  localparam logic [2:0] S_WL   = 3'd0;
  localparam logic [2:0] S_AA   = 3'd1;
  localparam logic [2:0] S_WD   = 3'd2;
  localparam logic [2:0] S_RDY  = 3'd3;
  localparam logic [2:0] S_RX   = 3'd4;
  localparam logic [2:0] S_FAIL = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clkwiz_locked = 1'b0;
  logic       restart = 1'b0;
  logic       busy;
  logic       error;
  logic [3:0] retry_count;
  logic [2:0] state;

  dcmac_reset_sequencer_if gt_if ();

  int vectors = 0;
  int errors  = 0;
  logic [13:0] exp_q[$];
  logic [13:0] exp_v;
  logic [13:0] got_v;

  // Clock/reset block
  always #5 clk = ~clk;

  dcmac_reset_sequencer #(
    .RESET_CYCLES  (RST_CYC),
    .TIMEOUT_CYCLES(TO_CYC),
    .MAX_RETRIES   (MAX_RT)
  ) dut (
    .s_axi_clk    (clk),
    .s_axi_aresetn(rst_n),
    .clkwiz_locked(clkwiz_locked),
    .restart      (restart),
    .gt           (gt_if.master),
    .busy         (busy),
    .error        (error),
    .retry_count  (retry_count),
    .state        (state)
  );

  // Output vector layout: {state, reset_all, rx_datapath, link_ready, busy, error, retry_count}
  function automatic logic [13:0] obs();
    return {state, gt_if.user_gt_reset_all, gt_if.user_gt_reset_rx_datapath,
            gt_if.link_ready, busy, error, retry_count};
  endfunction

  // Reference model: busy and error follow from the state alone.
  function automatic logic [13:0] mk(input logic [2:0] st, input logic ra,
                                     input logic [1:0] dp, input logic [1:0] lr,
                                     input logic [3:0] rc);
    logic b;
    logic e;
    b = !(st == S_RDY || st == S_FAIL);
    e = (st == S_FAIL);
    return {st, ra, dp, lr, b, e, rc};
  endfunction

  task automatic push(input int n, input logic [13:0] v);
    repeat (n) exp_q.push_back(v);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clkwiz_locked = 1'b0;
    restart = 1'b0;
    gt_if.gt_rx_reset_done = 2'b00;
    gt_if.gt_tx_reset_done = 2'b00;
    repeat (3) begin
      @(negedge clk);
      exp_v = mk(S_WL, 1'b1, 2'b00, 2'b00, 4'd0);
      got_v = obs();
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL reset_hold: got %b expected %b", got_v, exp_v);
      end
    end
    rst_n = 1'b1;
    push(3, mk(S_WL, 1'b1, 2'b00, 2'b00, 4'd0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = obs();
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL reset_release: got %b expected %b", got_v, exp_v);
      end
    end
  endtask

  task automatic test_bringup(input int done_delay);
    clkwiz_locked = 1'b1;
    push(2, mk(S_WL, 1'b1, 2'b00, 2'b00, 4'd0));
    push(RST_CYC, mk(S_AA, 1'b1, 2'b00, 2'b00, 4'd0));
    push(done_delay, mk(S_WD, 1'b0, 2'b00, 2'b00, 4'd0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = obs();
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL bringup: got %b expected %b", got_v, exp_v);
      end
    end
    gt_if.gt_rx_reset_done = 2'b11;
    gt_if.gt_tx_reset_done = 2'b11;
    push(4, mk(S_RDY, 1'b0, 2'b00, 2'b11, 4'd0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = obs();
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL bringup_ready: got %b expected %b", got_v, exp_v);
      end
    end
  endtask

  task automatic test_link_ready();
    logic [1:0] tx;
    repeat (3) begin
      tx = 2'($urandom_range(0, 2));
      gt_if.gt_tx_reset_done = tx;
      push(3, mk(S_RDY, 1'b0, 2'b00, tx, 4'd0));
      gt_if.gt_tx_reset_done = tx;
      while (exp_q.size() > 0) begin
        @(negedge clk);
        exp_v = exp_q.pop_front();
        got_v = obs();
        vectors++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL link_ready tx=%b: got %b expected %b", tx, got_v, exp_v);
        end
      end
      gt_if.gt_tx_reset_done = 2'b11;
      push(2, mk(S_RDY, 1'b0, 2'b00, 2'b11, 4'd0));
      while (exp_q.size() > 0) begin
        @(negedge clk);
        exp_v = exp_q.pop_front();
        got_v = obs();
        vectors++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL link_ready_restore: got %b expected %b", got_v, exp_v);
        end
      end
    end
  endtask

  task automatic test_rx_reset(input logic [1:0] rx_val, input int wd_cycles);
    gt_if.gt_rx_reset_done = rx_val;
    push(RST_CYC, mk(S_RX, 1'b0, ~rx_val, 2'b00, 4'd0));
    push(wd_cycles, mk(S_WD, 1'b0, 2'b00, 2'b00, 4'd0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = obs();
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL rx_reset rx=%b: got %b expected %b", rx_val, got_v, exp_v);
      end
    end
    gt_if.gt_rx_reset_done = 2'b11;
    push(3, mk(S_RDY, 1'b0, 2'b00, 2'b11, 4'd0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = obs();
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL rx_reset_recover rx=%b: got %b expected %b", rx_val, got_v, exp_v);
      end
    end
  endtask

  task automatic test_timeout();
    // Restart coincides with both rx bits dropping in READY; restart must win.
    gt_if.gt_rx_reset_done = 2'b00;
    gt_if.gt_tx_reset_done = 2'b00;
    restart = 1'b1;
    push(1, mk(S_AA, 1'b1, 2'b00, 2'b00, 4'd0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = obs();
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL timeout_restart: got %b expected %b", got_v, exp_v);
      end
    end
    restart = 1'b0;
    push(RST_CYC - 1, mk(S_AA, 1'b1, 2'b00, 2'b00, 4'd0));
    for (int r = 0; r <= MAX_RT; r++) begin
      push(TO_CYC, mk(S_WD, 1'b0, 2'b00, 2'b00, 4'(r)));
      if (r < MAX_RT) push(RST_CYC, mk(S_AA, 1'b1, 2'b00, 2'b00, 4'(r + 1)));
    end
    push(5, mk(S_FAIL, 1'b0, 2'b00, 2'b00, 4'(MAX_RT)));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = obs();
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL timeout_retry: got %b expected %b", got_v, exp_v);
      end
    end
  endtask

  task automatic test_fail_restart();
    restart = 1'b1;
    push(1, mk(S_AA, 1'b1, 2'b00, 2'b00, 4'd0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = obs();
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL fail_restart: got %b expected %b", got_v, exp_v);
      end
    end
    restart = 1'b0;
    push(10, mk(S_AA, 1'b1, 2'b00, 2'b00, 4'd0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = obs();
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL fail_restart_pulse: got %b expected %b", got_v, exp_v);
      end
    end
    // Lock drops with restart held; the synchronized lock loss reaches the FSM on the
    // third edge, where restart is still high and must lose.
    clkwiz_locked = 1'b0;
    restart = 1'b1;
    push(2, mk(S_AA, 1'b1, 2'b00, 2'b00, 4'd0));
    push(1, mk(S_WL, 1'b1, 2'b00, 2'b00, 4'd0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = obs();
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL lock_vs_restart: got %b expected %b", got_v, exp_v);
      end
    end
    restart = 1'b0;
    push(5, mk(S_WL, 1'b1, 2'b00, 2'b00, 4'd0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = obs();
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL lock_lost_hold: got %b expected %b", got_v, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] rx;
    int         k;
    gt_if.gt_rx_reset_done = 2'b11;
    gt_if.gt_tx_reset_done = 2'b11;
    clkwiz_locked = 1'b1;
    push(2, mk(S_WL, 1'b1, 2'b00, 2'b00, 4'd0));
    push(RST_CYC, mk(S_AA, 1'b1, 2'b00, 2'b00, 4'd0));
    push(1, mk(S_WD, 1'b0, 2'b00, 2'b00, 4'd0));
    push(3, mk(S_RDY, 1'b0, 2'b00, 2'b11, 4'd0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = obs();
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL relock: got %b expected %b", got_v, exp_v);
      end
    end
    rx = 2'($urandom_range(0, 2));
    k = $urandom_range(1, RST_CYC - 1);
    gt_if.gt_rx_reset_done = rx;
    push(k, mk(S_RX, 1'b0, ~rx, 2'b00, 4'd0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = obs();
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL async_pre rx=%b: got %b expected %b", rx, got_v, exp_v);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_v = mk(S_WL, 1'b1, 2'b00, 2'b00, 4'd0);
    got_v = obs();
    vectors++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL async_reset_immediate: got %b expected %b", got_v, exp_v);
    end
    @(negedge clk);
    got_v = obs();
    vectors++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL async_reset_hold: got %b expected %b", got_v, exp_v);
    end
    // Lock is still high, so a cleared synchronizer shows up as the full 2-cycle latency.
    rst_n = 1'b1;
    push(2, mk(S_WL, 1'b1, 2'b00, 2'b00, 4'd0));
    push(3, mk(S_AA, 1'b1, 2'b00, 2'b00, 4'd0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = obs();
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL async_release: got %b expected %b", got_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bringup(50);
    test_link_ready();
    test_rx_reset(2'b10, $urandom_range(1, 40));
    test_rx_reset(2'b00, $urandom_range(1, 40));
    test_rx_reset(2'($urandom_range(0, 2)), $urandom_range(1, 40));
    test_timeout();
    test_fail_restart();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dcmac_reset_sequencer.md
DCMAC_RESET_SEQUENCER -- requirements
Module: dcmac_reset_sequencer

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 100, reset-pulse width in clocks (range 1..65535).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, reset-done wait limit in clocks (range 1..2^32-1).
REQ-003 SHALL have parameter MAX_RETRIES, default 3, full-reset retries before failure (range 0..15).
REQ-004 SHALL use one clock, s_axi_clk; reset s_axi_aresetn is asynchronous, active-low; all state changes on the rising edge of s_axi_clk.
REQ-005 Port list:
- s_axi_clk  in  1  clock.
- s_axi_aresetn  in  1  asynchronous active-low reset.
- clkwiz_locked  in  1  clock-wizard lock; asynchronous.
- restart  in  1  single-cycle request for a full re-sequence.
- gt_rx_reset_done  in  2  per-port RX reset-done, already synchronous to s_axi_clk.
- gt_tx_reset_done  in  2  per-port TX reset-done, already synchronous to s_axi_clk.
- user_gt_reset_all  out  1  full GT reset to the DCMAC helper.
- user_gt_reset_rx_datapath  out  2  per-port RX datapath reset.
- link_ready  out  2  per-port: rx_done and tx_done both high while in READY.
- busy  out  1  high in every state except READY and FAIL.
- error  out  1  high in FAIL.
- retry_count  out  4  full-reset retries since the last READY entry.
- state  out  3  state encoding, for debug.

Function
REQ-006 SHALL synchronize clkwiz_locked with a 2-flop synchronizer, giving locked_s (2-cycle latency).
REQ-007 SHALL implement states encoded WAIT_LOCK=0, ASSERT_ALL=1, WAIT_DONE=2, READY=3, RX_RESET=4, FAIL=5.
REQ-008 All outputs SHALL be registered; an output responds one clock after the condition that drives it.
REQ-009 WAIT_LOCK:
- user_gt_reset_all=1.
- On locked_s=1 -> ASSERT_ALL; pulse counter loaded.
REQ-010 ASSERT_ALL:
- user_gt_reset_all=1 for exactly RESET_CYCLES clocks.
- Then -> WAIT_DONE; timeout timer cleared.
REQ-011 WAIT_DONE:
- user_gt_reset_all=0; timer increments each clock.
- When gt_rx_reset_done==2'b11 and gt_tx_reset_done==2'b11 -> READY; retry_count cleared.
REQ-012 WAIT_DONE timeout: when timer reaches TIMEOUT_CYCLES without done:
- If retry_count < MAX_RETRIES -> retry_count+1, then ASSERT_ALL.
- Otherwise -> FAIL.
- If done and timeout occur in the same cycle, done wins.
REQ-013 READY: link_ready[p] = gt_rx_reset_done[p] & gt_tx_reset_done[p].
REQ-014 READY: if any gt_rx_reset_done bit is low -> RX_RESET.
- Latch mask = ~gt_rx_reset_done.
- If both ports drop in the same cycle, both mask bits are set.
REQ-015 RX_RESET:
- user_gt_reset_rx_datapath = mask for exactly RESET_CYCLES clocks; unmasked bits stay 0.
- Then -> WAIT_DONE; timer cleared; retry_count unchanged.
REQ-016 FAIL:
- All reset outputs 0; error=1.
- Exit only via restart or lock loss.
REQ-017 restart=1 in any state except WAIT_LOCK -> ASSERT_ALL next clock.
- retry_count cleared; mask cleared; user_gt_reset_rx_datapath=0.
REQ-018 locked_s=0 in any state -> WAIT_LOCK next clock.
- Lock loss has priority over restart, which has priority over all other transitions.
REQ-019 The timer SHALL be 32-bit and saturating; retry_count SHALL never exceed MAX_RETRIES.

Reset
REQ-020 While s_axi_aresetn=0:
- state=WAIT_LOCK, user_gt_reset_all=1, user_gt_reset_rx_datapath=0.
- link_ready=0, busy=1, error=0, retry_count=0.
- Timer, pulse counter, mask and both synchronizer flops cleared.
REQ-021 Assertion of s_axi_aresetn mid-sequence SHALL abort immediately and asynchronously to the values in REQ-020.

Verification
REQ-022 Bench SHALL cover: reset release, locked rises, dones rise 50 clocks after reset_all falls -> reset_all high exactly 100 clocks after locked_s, then READY, link_ready=2'b11, busy=0.
REQ-023 Bench SHALL cover: dones never rise, TIMEOUT_CYCLES=1000 -> three more 100-clock reset_all pulses, retry_count steps 1..3, then FAIL with error=1, reset_all=0.
REQ-024 Bench SHALL cover: in READY, gt_rx_reset_done drops to 2'b10 -> user_gt_reset_rx_datapath=2'b01 for 100 clocks, bit1 stays 0, then WAIT_DONE, then READY once done returns.
REQ-025 Bench SHALL cover: in READY, both rx_done bits drop in the same cycle -> user_gt_reset_rx_datapath=2'b11 for 100 clocks.
REQ-026 Bench SHALL cover: restart and clkwiz_locked fall together during ASSERT_ALL -> WAIT_LOCK wins, reset_all stays 1; then restart in FAIL -> ASSERT_ALL with retry_count=0, error=0.
REQ-027 Bench SHALL cover: s_axi_aresetn asserted during RX_RESET -> outputs take the REQ-020 values with no clock edge.
